compare_feeder: RTL and testbench

Transmit side of the compare/max-pool threshold interface. Two input streams feed this block: a byte stream of per-channel 24-bit packed thresholds, and a stream of 7-bit signed activations. It loads each channel's threshold into the downstream comparator with a clean strobe. It then packs activations into 49-bit, 7-lane pooling windows. It also produces a valid flag aligned to the comparator's binary result.

---
 rtl/compare_feeder_if.sv | 37 +++
 rtl/compare_feeder.sv | 141 ++++++++++++++
 tb/tb_compare_feeder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/compare_feeder_if.sv
// compare_feeder_if: threshold byte stream, activation stream and
// comparator-side outputs of the compare/max-pool threshold feeder.
`default_nettype none

interface compare_feeder_if #(
  parameter int DATA_W = 7,
  parameter int LANES  = 7,
  parameter int THR_W  = 24
);
  logic [7:0]              thr_byte_in;
  logic                    thr_byte_valid;
  logic                    thr_byte_ready;
  logic [DATA_W-1:0]       act_in;
  logic                    act_valid;
  logic                    act_last;
  logic                    act_ready;
  logic [DATA_W*LANES-1:0] in_Data;
  logic                    data_valid;
  logic [THR_W-1:0]        threhold;
  logic                    loadthrehold;
  logic                    bin_valid;
  logic                    busy;

  modport master (
    output thr_byte_in, thr_byte_valid, act_in, act_valid, act_last,
    input  thr_byte_ready, act_ready, in_Data, data_valid, threhold,
           loadthrehold, bin_valid, busy
  );

  modport slave (
    input  thr_byte_in, thr_byte_valid, act_in, act_valid, act_last,
    output thr_byte_ready, act_ready, in_Data, data_valid, threhold,
           loadthrehold, bin_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/compare_feeder.sv
// compare_feeder: loads a per-channel 24-bit threshold with a clean strobe,
// then packs signed activations into 7-lane pooling windows for the comparator.
`default_nettype none

module compare_feeder #(
  parameter int DATA_W  = 7,
  parameter int LANES   = 7,
  parameter int THR_W   = 24,
  parameter int CMP_LAT = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  compare_feeder_if.slave  bus
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_THR_B0     = 3'd1;
  localparam logic [2:0] c_THR_B1     = 3'd2;
  localparam logic [2:0] c_THR_B2     = 3'd3;
  localparam logic [2:0] c_THR_SETUP  = 3'd4;
  localparam logic [2:0] c_THR_STROBE = 3'd5;
  localparam logic [2:0] c_STREAM     = 3'd6;

  localparam logic [CNT_W-1:0]  c_LAST_LANE = CNT_W'(LANES - 1);
  // Most negative activation: padding lanes can never win the max.
  localparam logic [DATA_W-1:0] c_PAD = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]              r_state;
  logic [15:0]             r_shadow;
  logic [THR_W-1:0]        r_thr;
  logic                    r_load;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_lane [LANES];
  logic [DATA_W*LANES-1:0] r_in_data;
  logic                    r_dv;
  logic [CMP_LAT-1:0]      r_bv;

  logic                    w_thr_ready;
  logic                    w_act_ready;
  logic                    w_thr_acc;
  logic                    w_act_acc;
  logic                    w_emit;
  logic [DATA_W*LANES-1:0] w_window;

  assign w_thr_ready = (r_state == c_THR_B0) || (r_state == c_THR_B1) ||
                       (r_state == c_THR_B2);
  assign w_act_ready = (r_state == c_STREAM);
  assign w_thr_acc   = w_thr_ready && bus.thr_byte_valid;
  assign w_act_acc   = w_act_ready && bus.act_valid;
  assign w_emit      = w_act_acc && ((r_cnt == c_LAST_LANE) || bus.act_last);

  // Stored lanes below cnt, the live sample at cnt, padding above it.
  always_comb begin
    w_window = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(r_cnt))
        w_window[(LANES-1-i)*DATA_W +: DATA_W] = r_lane[i];
      else if (i == int'(r_cnt))
        w_window[(LANES-1-i)*DATA_W +: DATA_W] = bus.act_in;
      else
        w_window[(LANES-1-i)*DATA_W +: DATA_W] = c_PAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_shadow  <= '0;
      r_thr     <= '0;
      r_load    <= 1'b0;
      r_cnt     <= '0;
      r_in_data <= '0;
      r_dv      <= 1'b0;
      for (int i = 0; i < LANES; i++) r_lane[i] <= '0;
    end else begin
      r_dv   <= 1'b0;
      r_load <= 1'b0;
      case (r_state)
        c_IDLE: r_state <= c_THR_B0;
        c_THR_B0: if (w_thr_acc) begin
          r_shadow[15:8] <= bus.thr_byte_in;
          r_state        <= c_THR_B1;
        end
        c_THR_B1: if (w_thr_acc) begin
          r_shadow[7:0] <= bus.thr_byte_in;
          r_state       <= c_THR_B2;
        end
        c_THR_B2: if (w_thr_acc) begin
          r_thr   <= {r_shadow, bus.thr_byte_in};
          r_state <= c_THR_SETUP;
        end
        c_THR_SETUP: begin
          r_load  <= 1'b1;
          r_state <= c_THR_STROBE;
        end
        c_THR_STROBE: r_state <= c_STREAM;
        c_STREAM: if (w_act_acc) begin
          r_lane[r_cnt] <= bus.act_in;
          if (w_emit) begin
            r_in_data <= w_window;
            r_dv      <= 1'b1;
            r_cnt     <= '0;
            if (bus.act_last) r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // bin_valid tracks data_valid through the comparator pipeline in every state.
  generate
    if (CMP_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_bv <= '0;
        else        r_bv <= r_dv;
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_bv <= '0;
        else        r_bv <= {r_bv[CMP_LAT-2:0], r_dv};
      end
    end
  endgenerate

  assign bus.thr_byte_ready = w_thr_ready;
  assign bus.act_ready      = w_act_ready;
  assign bus.in_Data        = r_in_data;
  assign bus.data_valid     = r_dv;
  assign bus.threhold       = r_thr;
  assign bus.loadthrehold   = r_load;
  assign bus.bin_valid      = r_bv[CMP_LAT-1];
  assign bus.busy           = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_compare_feeder.sv
// tb_compare_feeder: directed vectors with hand-computed windows and
// thresholds for the compare_feeder threshold/window transmitter.
`default_nettype none

module tb_compare_feeder;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  int   dv_count;
  int   bv_count;

  compare_feeder_if #(.DATA_W(7), .LANES(7), .THR_W(24)) bus ();

  compare_feeder #(.DATA_W(7), .LANES(7), .THR_W(24), .CMP_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.data_valid) dv_count++;
    if (bus.bin_valid)  bv_count++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] v, input logic last);
    bus.act_in    = v;
    bus.act_valid = 1'b1;
    bus.act_last  = last;
    tick();
    bus.act_valid = 1'b0;
    bus.act_last  = 1'b0;
  endtask

  task automatic load_thr(input logic [23:0] thr, input logic [23:0] old_thr,
                          input logic noise);
    int n;
    bus.act_valid = noise;
    bus.act_in    = 7'h33;
    n = 0;
    while (!bus.thr_byte_ready && n < 20) begin
      tick();
      n++;
    end
    chk("thr_ready", 64'(bus.thr_byte_ready), 64'd1);
    bus.thr_byte_valid = 1'b1;
    bus.thr_byte_in = thr[23:16]; tick();
    bus.thr_byte_in = thr[15:8];  tick();
    chk("thr_hold_b2", 64'(bus.threhold), 64'(old_thr));
    chk("act_ready_thr", 64'(bus.act_ready), 64'd0);
    bus.thr_byte_in = thr[7:0];   tick();
    bus.thr_byte_valid = 1'b0;
    bus.act_valid      = 1'b0;
    chk("thr_value", 64'(bus.threhold), 64'(thr));
    chk("load_setup", 64'(bus.loadthrehold), 64'd0);
    tick();
    chk("load_strobe", 64'(bus.loadthrehold), 64'd1);
    chk("ready_in_strobe", 64'(bus.act_ready), 64'd0);
    tick();
    chk("load_fall", 64'(bus.loadthrehold), 64'd0);
    chk("act_ready_up", 64'(bus.act_ready), 64'd1);
  endtask

  initial begin
    int c0, c1, b1, p0, p1;
    logic [48:0] exp_w;
    n_total = 0; n_bad = 0; dv_count = 0; bv_count = 0;
    bus.thr_byte_in = 8'h00; bus.thr_byte_valid = 1'b0;
    bus.act_in = 7'h00; bus.act_valid = 1'b0; bus.act_last = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_in_data", 64'(bus.in_Data), 64'd0);
    chk("rst_thr", 64'(bus.threhold), 64'd0);
    chk("rst_load", 64'(bus.loadthrehold), 64'd0);
    chk("rst_dv", 64'(bus.data_valid), 64'd0);
    chk("rst_bv", 64'(bus.bin_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;

    // Threshold 0x812345
    load_thr(24'h812345, 24'h000000, 1'b0);

    // Full window 1..7
    for (int i = 1; i <= 7; i++) begin
      send(7'(i), 1'b0);
      chk("w1_dv", 64'(bus.data_valid), (i == 7) ? 64'd1 : 64'd0);
    end
    exp_w = {7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7};
    chk("w1_data", 64'(bus.in_Data), 64'(exp_w));
    tick();
    chk("w1_dv_pulse", 64'(bus.data_valid), 64'd0);
    chk("w1_bv_early", 64'(bus.bin_valid), 64'd0);
    chk("w1_hold", 64'(bus.in_Data), 64'(exp_w));
    tick();
    chk("w1_bv", 64'(bus.bin_valid), 64'd1);
    tick();
    chk("w1_bv_pulse", 64'(bus.bin_valid), 64'd0);

    // Short window with act_last: 10, -3, 5 then padding
    send(7'd10, 1'b0);
    send(7'h7D, 1'b0);
    send(7'd5, 1'b1);
    chk("w2_dv", 64'(bus.data_valid), 64'd1);
    exp_w = {7'd10, 7'h7D, 7'd5, 7'h40, 7'h40, 7'h40, 7'h40};
    chk("w2_data", 64'(bus.in_Data), 64'(exp_w));
    chk("w2_idle", 64'(bus.busy), 64'd0);
    chk("w2_thr_rdy_idle", 64'(bus.thr_byte_ready), 64'd0);
    tick();
    chk("w2_thr_rdy", 64'(bus.thr_byte_ready), 64'd1);

    // Reload with act_valid held high during threshold states
    load_thr(24'h7F0102, 24'h812345, 1'b1);

    // Gapped stream with thr_byte_valid noise
    c0 = dv_count;
    begin
      logic [6:0] vals [7];
      vals = '{7'h7F, 7'h40, 7'h3F, 7'h00, 7'h02, 7'h7E, 7'h04};
      for (int i = 0; i < 7; i++) begin
        send(vals[i], 1'b0);
        chk("w3_dv", 64'(bus.data_valid), (i == 6) ? 64'd1 : 64'd0);
        bus.thr_byte_valid = 1'b1;
        bus.thr_byte_in    = 8'hFF;
        tick();
        chk("w3_thr_rdy", 64'(bus.thr_byte_ready), 64'd0);
        bus.thr_byte_valid = 1'b0;
      end
    end
    exp_w = {7'h7F, 7'h40, 7'h3F, 7'h00, 7'h02, 7'h7E, 7'h04};
    chk("w3_data", 64'(bus.in_Data), 64'(exp_w));
    chk("w3_thr", 64'(bus.threhold), 64'h7F0102);
    chk("w3_dv_count", 64'(dv_count - c0), 64'd1);

    // 14 back-to-back, last on the 14th
    c0 = dv_count; p0 = -1; p1 = -1;
    for (int i = 0; i < 14; i++) begin
      send(7'(41 + i), i == 13);
      if (bus.data_valid) begin
        if (p0 < 0) p0 = i; else p1 = i;
      end
      if (i == 6) begin
        exp_w = {7'd41, 7'd42, 7'd43, 7'd44, 7'd45, 7'd46, 7'd47};
        chk("w4a_data", 64'(bus.in_Data), 64'(exp_w));
      end
    end
    exp_w = {7'd48, 7'd49, 7'd50, 7'd51, 7'd52, 7'd53, 7'd54};
    chk("w4b_data", 64'(bus.in_Data), 64'(exp_w));
    chk("w4_p0", 64'(p0), 64'd6);
    chk("w4_p1", 64'(p1), 64'd13);
    tick(); tick(); tick();
    chk("w4_dv_count", 64'(dv_count - c0), 64'd2);
    chk("w4_busy", 64'(bus.busy), 64'd1);

    // Reset after 4 of 7 activations
    load_thr(24'h123456, 24'h7F0102, 1'b0);
    for (int i = 0; i < 4; i++) send(7'(20 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_data", 64'(bus.in_Data), 64'd0);
    chk("mid_rst_thr", 64'(bus.threhold), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_act_rdy", 64'(bus.act_ready), 64'd0);
    chk("mid_rst_dv", 64'(bus.data_valid), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    c1 = dv_count; b1 = bv_count;
    load_thr(24'h0F0F0F, 24'h000000, 1'b0);
    chk("post_rst_no_dv", 64'(dv_count - c1), 64'd0);
    chk("post_rst_no_bv", 64'(bv_count - b1), 64'd0);
    for (int i = 0; i < 7; i++) send(7'(30 + i), 1'b0);
    exp_w = {7'd30, 7'd31, 7'd32, 7'd33, 7'd34, 7'd35, 7'd36};
    chk("w5_dv", 64'(bus.data_valid), 64'd1);
    chk("w5_data", 64'(bus.in_Data), 64'(exp_w));
    tick(); tick();
    chk("w5_bv", 64'(bus.bin_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
